spi_rx: RTL

SPI receiver (responder side) for the team's 8-bit SPI transmitter: ss active-high frames the transfer, sck idles low, mosi is MSB-first and sampled on the sck rising edge.
- Runs on the system clk (100 MHz). Oversamples and synchronises the asynchronous sck/ss/mosi lines.
- Assembles one word per frame and presents it with a one-cycle valid pulse. Flags malformed frames.

---
 rtl/spi_rx_if.sv | 24 ++
 rtl/spi_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_rx_if.sv
// Serial-line and receive-result bundle between an 8-bit SPI transmitter and spi_rx.
interface spi_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sck;
  logic                  ss;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] dataRX;
  logic                  rxValid;
  logic                  frameErr;
  logic                  busy;

  // Transmitter side: drives the serial lines, observes the receiver results.
  modport master (
    output sck, ss, mosi,
    input  dataRX, rxValid, frameErr, busy
  );

  // Receiver side.
  modport slave (
    input  sck, ss, mosi,
    output dataRX, rxValid, frameErr, busy
  );
endinterface

// File: rtl/spi_rx.sv
// SPI responder receiver: oversamples sck/ss/mosi on clk, assembles one
// MSB-first word per ss-framed transfer, pulses rxValid or frameErr.
module spi_rx #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    rst,
  spi_rx_if.slave bus
);

  localparam int unsigned    CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_ERROR
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] sync_fill_q;
  logic                   sck_d_q;
  logic                   ss_d_q;

  logic sck_s;
  logic ss_s;
  logic mosi_s;
  logic sck_rise;
  logic ss_rise;
  logic ss_fall;

  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic                  rx_valid_q,  rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q,      busy_d;

  // Equal-depth synchronisers keep mosi aligned with the sck edge that samples it.
  // sync_fill_q marks when the chains hold post-reset samples rather than reset zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sync_fill_q <= '0;
      sck_d_q     <= 1'b0;
      ss_d_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  bus.sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   bus.ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sync_fill_q <= {sync_fill_q[SYNC_STAGES-2:0], 1'b1};
      sck_d_q     <= sck_s;
      ss_d_q      <= ss_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d_q;
  assign ss_rise  = ss_s & ~ss_d_q;
  assign ss_fall  = ~ss_s & ss_d_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ARM;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, shift/count update and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      // ARM waits for trustworthy synchroniser output showing ss low, so a
      // frame already in flight at reset release is never joined halfway.
      ST_ARM: begin
        cnt_d   = '0;
        shift_d = '0;
        if (sync_fill_q[SYNC_STAGES-1] && !ss_s) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        cnt_d   = '0;
        shift_d = '0;
        if (ss_rise) begin
          state_d = ST_SHIFT;
        end
      end

      // The final bit wins over a coincident ss fall; any earlier ss fall,
      // including one landing with a non-final bit, drops the partial word.
      ST_SHIFT: begin
        if (sck_rise && (cnt_q == LAST_BIT)) begin
          data_d     = {shift_q[DATA_WIDTH-2:0], mosi_s};
          rx_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else if (ss_fall) begin
          state_d = ST_ERROR;
        end else if (sck_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      // Word delivered; an extra sck edge before ss drops is an overrun.
      // Level test on ss covers an ss fall already seen alongside the last bit.
      ST_DONE: begin
        if (sck_rise) begin
          state_d = ST_ERROR;
        end else if (!ss_s) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERROR: begin
        state_d = ST_ARM;
      end

      default: begin
        state_d = ST_ARM;
      end
    endcase

    busy_d      = (state_d == ST_SHIFT) || (state_d == ST_DONE);
    frame_err_d = (state_d == ST_ERROR);
  end

  assign bus.dataRX   = data_q;
  assign bus.rxValid  = rx_valid_q;
  assign bus.frameErr = frame_err_q;
  assign bus.busy     = busy_q;

endmodule
